// File: rtl/countdown_pkg.sv
// Shared definitions for the loadable countdown timer.
package countdown_pkg;

  localparam int unsigned STATE_W = 2;

  // Controller states; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_EXPIRE = 2'd2
  } state_t;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, abort, one-cycle done pulse
// and optional periodic auto-reload from the last loaded value.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;

  // Single decrement step; callers guarantee the operand is above one.
  function automatic logic [WIDTH-1:0] dec_one(input logic [WIDTH-1:0] value);
    return value - WIDTH'(1);
  endfunction

  // State, remaining count and reload value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            count      <= load_value;
            reload_reg <= load_value;
            state      <= (load_value == '0) ? ST_EXPIRE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (enable) begin
            // Last step (or a defensive zero) leaves RUN so count never wraps.
            if (count <= WIDTH'(1)) begin
              count <= '0;
              state <= ST_EXPIRE;
            end else begin
              count <= dec_one(count);
            end
          end
        end
        ST_EXPIRE: begin
          if (AUTO_RELOAD && !abort && (reload_reg != '0)) begin
            count <= reload_reg;
            state <= ST_RUN;
          end else begin
            count <= '0;
            state <= ST_IDLE;
          end
        end
        default: begin
          count <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_ready = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    done       = (state == ST_EXPIRE);
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: one-shot instance (a) and
// auto-reload instance (b). Stimulus queues expected snapshots and done
// cycles; a negedge monitor compares them against the DUT outputs.
module tb_countdown_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         a_lv, a_lr, a_en, a_ab, a_busy, a_done;
  logic [W-1:0] a_lval, a_cnt;
  logic         b_lv, b_lr, b_en, b_ab, b_busy, b_done;
  logic [W-1:0] b_lval, b_cnt;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int cyc;
    int inst;
    int cnt;
    int busy;
    int ready;
    int done;
  } snap_t;

  snap_t sq[$];
  int    dq_a[$];
  int    dq_b[$];

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_lr),
    .load_value(a_lval), .enable(a_en), .abort(a_ab), .count(a_cnt),
    .busy(a_busy), .done(a_done)
  );

  countdown_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_lr),
    .load_value(b_lval), .enable(b_en), .abort(b_ab), .count(b_cnt),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  // Edge index: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endtask

  task automatic push_snap(input int inst, input int c, input int cnt,
                           input int busy, input int ready, input int done);
    snap_t s;
    s.cyc = c; s.inst = inst; s.cnt = cnt;
    s.busy = busy; s.ready = ready; s.done = done;
    sq.push_back(s);
  endtask

  task automatic push_idle(input int inst, input int c);
    push_snap(inst, c, 0, 0, 1, 0);
  endtask

  task automatic push_done(input int inst, input int c);
    if (inst == 0) dq_a.push_back(c);
    else dq_b.push_back(c);
  endtask

  // Uninterrupted count of n from edge e: n..1, expiry at e+n, idle at e+n+1.
  task automatic push_run(input int inst, input int e, input int n);
    for (int k = 0; k < n; k++) push_snap(inst, e + k, n - k, 1, 0, 0);
    push_snap(inst, e + n, 0, 1, 0, 1);
    push_idle(inst, e + n + 1);
    push_done(inst, e + n);
  endtask

  // Called at a negedge; the load is accepted on the following edge e.
  task automatic issue(input int inst, input int n, output int e);
    if (inst == 0) begin a_lv = 1'b1; a_lval = W'(n); end
    else begin b_lv = 1'b1; b_lval = W'(n); end
    e = cyc + 1;
  endtask

  task automatic drop_load();
    @(negedge clk);
    a_lv = 1'b0;
    b_lv = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare queued snapshots and done pulses away from the rising edge.
  always @(negedge clk) begin
    snap_t x;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      x = sq.pop_front();
      if (x.cyc < cyc) begin
        check("late_snapshot", cyc, x.cyc);
      end else if (x.inst == 0) begin
        check("a.count", int'(a_cnt), x.cnt);
        check("a.busy", int'(a_busy), x.busy);
        check("a.load_ready", int'(a_lr), x.ready);
        check("a.done", int'(a_done), x.done);
      end else begin
        check("b.count", int'(b_cnt), x.cnt);
        check("b.busy", int'(b_busy), x.busy);
        check("b.load_ready", int'(b_lr), x.ready);
        check("b.done", int'(b_done), x.done);
      end
    end
    if (a_done) begin
      if (dq_a.size() == 0) check("a.done_unexpected", int'(a_done), 0);
      else check("a.done_cycle", cyc, dq_a.pop_front());
    end else if (dq_a.size() > 0 && dq_a[0] < cyc) begin
      check("a.done_missed", int'(a_done), 1);
      void'(dq_a.pop_front());
    end
    if (b_done) begin
      if (dq_b.size() == 0) check("b.done_unexpected", int'(b_done), 0);
      else check("b.done_cycle", cyc, dq_b.pop_front());
    end else if (dq_b.size() > 0 && dq_b[0] < cyc) begin
      check("b.done_missed", int'(b_done), 1);
      void'(dq_b.pop_front());
    end
  end

  // Directed stimulus.
  initial begin
    int e;
    int cnts[8];
    a_lv = 1'b0; a_lval = '0; a_en = 1'b1; a_ab = 1'b0;
    b_lv = 1'b0; b_lval = '0; b_en = 1'b1; b_ab = 1'b0;

    // Reset state
    #1;
    check("rst.a.count", int'(a_cnt), 0);
    check("rst.a.busy", int'(a_busy), 0);
    check("rst.a.done", int'(a_done), 0);
    check("rst.a.load_ready", int'(a_lr), 1);
    check("rst.b.load_ready", int'(b_lr), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // One-shot load 5
    issue(0, 5, e);
    push_run(0, e, 5);
    drop_load();
    wait_until(e + 6);

    // Pause: load 4, enable low on three edges
    @(negedge clk);
    issue(0, 4, e);
    cnts = '{4, 3, 3, 3, 3, 2, 1, 0};
    for (int i = 0; i < 7; i++) push_snap(0, e + i, cnts[i], 1, 0, 0);
    push_snap(0, e + 7, cnts[7], 1, 0, 1);
    push_idle(0, e + 8);
    push_done(0, e + 7);
    drop_load();
    @(negedge clk);
    a_en = 1'b0;
    repeat (3) @(negedge clk);
    a_en = 1'b1;
    wait_until(e + 8);

    // Abort at count 6, then immediate reload of 2
    @(negedge clk);
    issue(0, 10, e);
    for (int k = 0; k < 5; k++) push_snap(0, e + k, 10 - k, 1, 0, 0);
    push_idle(0, e + 5);
    push_run(0, e + 6, 2);
    drop_load();
    wait_until(e + 4);
    a_ab = 1'b1;
    @(negedge clk);
    a_ab = 1'b0;
    a_lv = 1'b1;
    a_lval = W'(2);
    @(negedge clk);
    a_lv = 1'b0;
    wait_until(e + 9);

    // Load 0 expires on the next cycle
    @(negedge clk);
    issue(0, 0, e);
    push_snap(0, e, 0, 1, 0, 1);
    push_idle(0, e + 1);
    push_done(0, e);
    drop_load();
    wait_until(e + 1);

    // Full-scale load 255, no wrap
    @(negedge clk);
    issue(0, 255, e);
    push_snap(0, e, 255, 1, 0, 0);
    push_snap(0, e + 128, 127, 1, 0, 0);
    push_snap(0, e + 254, 1, 1, 0, 0);
    push_snap(0, e + 255, 0, 1, 0, 1);
    push_idle(0, e + 256);
    push_done(0, e + 255);
    drop_load();
    wait_until(e + 256);

    // Asynchronous reset mid-count
    @(negedge clk);
    issue(0, 10, e);
    push_snap(0, e, 10, 1, 0, 0);
    push_snap(0, e + 1, 9, 1, 0, 0);
    drop_load();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.a.count", int'(a_cnt), 0);
    check("rstmid.a.busy", int'(a_busy), 0);
    check("rstmid.a.load_ready", int'(a_lr), 1);
    check("rstmid.a.done", int'(a_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(0, cyc + 1);
    repeat (2) @(negedge clk);

    // Auto-reload load 3: done every 4 cycles, abort during the sixth EXPIRE
    issue(1, 3, e);
    for (int p = 0; p < 6; p++) begin
      push_snap(1, e + 4 * p, 3, 1, 0, 0);
      push_snap(1, e + 4 * p + 1, 2, 1, 0, 0);
      push_snap(1, e + 4 * p + 2, 1, 1, 0, 0);
      push_snap(1, e + 4 * p + 3, 0, 1, 0, 1);
      push_done(1, e + 4 * p + 3);
    end
    push_idle(1, e + 24);
    push_idle(1, e + 26);
    drop_load();
    wait_until(e + 23);
    b_ab = 1'b1;
    @(negedge clk);
    b_ab = 1'b0;
    wait_until(e + 26);
    repeat (3) @(negedge clk);

    check("snapshots_pending", sq.size(), 0);
    check("a.done_pending", dq_a.size(), 0);
    check("b.done_pending", dq_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_countdown_timer
